bcd_serial_adder: RTL and testbench

//   Parametrised multi-digit BCD adder/subtractor with start/done handshake.

---
 rtl/bcd_serial_adder_if.sv | 27 ++
 rtl/bcd_serial_adder.sv | 142 ++++++++++++++
 tb/tb_bcd_serial_adder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_if.sv
// Handshake/bus bundle for bcd_serial_adder.
//   master: drives start/sub/cin/a/b, observes busy/done/sum/cout/err
//   slave : the adder itself
interface bcd_serial_adder_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic                  cin;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one decimal digit per clock, LSD first.
//   i_clk  : rising-edge clock
//   i_rst  : synchronous active-high reset
//   io_bus : slave side of bcd_serial_adder_if
//            start/sub/cin/a/b in; busy/done/sum/cout/err out
// Subtraction uses 10's complement: each B digit is replaced by 9-b and the
// initial carry is the inverted borrow-in. cout on subtract means "no borrow".
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bcd_serial_adder_if.slave    io_bus
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  state_e          w_state_next;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_shift;
  logic [W-1:0]    r_sum;
  logic            r_sub;
  logic            r_c;
  logic            r_cout;
  logic            r_err;
  logic [IdxW-1:0] r_idx;

  logic            w_accept;
  logic            w_bad;
  logic            w_last;
  logic [3:0]      w_bd;
  logic [4:0]      w_t;
  logic [3:0]      w_digit;
  logic            w_c_next;
  logic [W-1:0]    w_digit_ext;
  logic [W-1:0]    w_shift_next;

  // New operations are taken in IDLE and in the DONE cycle (back-to-back).
  assign w_accept = (r_state != StRun) && io_bus.start;
  assign w_last   = (r_idx == IdxW'(DIGITS - 1));

  always_comb begin
    w_bad = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if ((io_bus.a[4*k +: 4] > 4'd9) || (io_bus.b[4*k +: 4] > 4'd9)) begin
        w_bad = 1'b1;
      end
    end
  end

  // Single-digit decimal stage; operands are shifted so digit i is always at [3:0].
  always_comb begin
    w_bd     = r_sub ? (4'd9 - r_b[3:0]) : r_b[3:0];
    w_t      = {1'b0, r_a[3:0]} + {1'b0, w_bd} + {4'd0, r_c};
    w_c_next = (w_t > 5'd9);
    w_digit  = w_c_next ? (w_t[3:0] + 4'd6) : w_t[3:0];
  end

  // Digits enter at the top and migrate down, so after DIGITS steps digit0 sits at [3:0].
  always_comb begin
    w_digit_ext       = '0;
    w_digit_ext[3:0]  = w_digit;
    w_shift_next      = (r_shift >> 4) | (w_digit_ext << (4 * (DIGITS - 1)));
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_accept) begin
          w_state_next = w_bad ? StDone : StRun;
        end else begin
          w_state_next = StIdle;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_next = StDone;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Result registers only change when entering DONE, never mid-operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_shift <= '0;
      r_sum   <= '0;
      r_sub   <= 1'b0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_a   <= io_bus.a;
      r_b   <= io_bus.b;
      r_sub <= io_bus.sub;
      r_c   <= io_bus.sub ? ~io_bus.cin : io_bus.cin;
      r_idx <= '0;
      if (w_bad) begin
        r_sum  <= '0;
        r_cout <= 1'b0;
        r_err  <= 1'b1;
      end
    end else if (r_state == StRun) begin
      r_a     <= r_a >> 4;
      r_b     <= r_b >> 4;
      r_c     <= w_c_next;
      r_idx   <= r_idx + IdxW'(1);
      r_shift <= w_shift_next;
      if (w_last) begin
        r_sum  <= w_shift_next;
        r_cout <= w_c_next;
        r_err  <= 1'b0;
      end
    end
  end

  assign io_bus.busy = (r_state == StRun);
  assign io_bus.done = (r_state == StDone);
  assign io_bus.sum  = r_sum;
  assign io_bus.cout = r_cout;
  assign io_bus.err  = r_err;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder: a 4-digit and a 1-digit instance, checked against
// a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(4)) bus4 ();
  bcd_serial_adder_if #(.DIGITS(1)) bus1 ();

  bcd_serial_adder #(.DIGITS(4)) u_dut4 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus4)
  );

  bcd_serial_adder #(.DIGITS(1)) u_dut1 (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus1)
  );

  // ---------------- reference model ----------------
  function automatic longint bcd2int(input logic [15:0] v, input int d);
    longint r = 0;
    for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input longint v, input int d);
    logic [15:0] r = '0;
    longint      x = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic ref_model(input logic [15:0] a, input logic [15:0] b, input bit s, input bit c,
                           input int d, output logic [15:0] es, output bit ec, output bit ee);
    longint pw = 1;
    longint t;
    ee = 1'b0;
    for (int i = 0; i < d; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) ee = 1'b1;
      pw = pw * 10;
    end
    if (ee) begin
      es = '0;
      ec = 1'b0;
    end else if (!s) begin
      t  = bcd2int(a, d) + bcd2int(b, d) + longint'(c);
      ec = (t >= pw);
      es = int2bcd(t % pw, d);
    end else begin
      t  = bcd2int(a, d) - bcd2int(b, d) - longint'(c);
      ec = (t >= 0);
      if (t < 0) t = t + pw;
      es = int2bcd(t, d);
    end
  endtask

  function automatic logic [15:0] rand_bcd(input bit allow_bad);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'($urandom_range(9));
      if (allow_bad && $urandom_range(15) == 0) r[4*i +: 4] = 4'($urandom_range(15, 10));
    end
    return r;
  endfunction

  // ---------------- 4-digit operation ----------------
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit s, input bit c,
                        input string name);
    logic [15:0] es, p_sum;
    bit          ec, ee, p_cout, p_err, stable;
    int          cyc, busy_cnt, exp_lat, exp_busy;
    ref_model(a, b, s, c, 4, es, ec, ee);
    exp_lat  = ee ? 1 : 5;
    exp_busy = ee ? 0 : 4;
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.sub = s; bus4.cin = c;
    p_sum = bus4.sum; p_cout = bus4.cout; p_err = bus4.err;
    stable = 1'b1; cyc = 0; busy_cnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus4.start = 1'b0;
      if (bus4.busy) begin
        busy_cnt++;
        // Operands are latched: scramble inputs and poke start while running.
        bus4.a     = rand_bcd(1'b1);
        bus4.b     = rand_bcd(1'b1);
        bus4.sub   = 1'($urandom_range(1));
        bus4.cin   = 1'($urandom_range(1));
        bus4.start = 1'($urandom_range(1));
      end
      if (!bus4.done && (bus4.sum !== p_sum || bus4.cout !== p_cout || bus4.err !== p_err))
        stable = 1'b0;
    end while (!bus4.done && cyc < 20);
    bus4.start = 1'b0;
    n_vec++;
    if (cyc !== exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
    end
    n_vec++;
    if (busy_cnt !== exp_busy) begin
      n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, exp_busy);
    end
    n_vec++;
    if (stable !== 1'b1) begin
      n_err++; $display("FAIL %s outputs_stable: got %0b want 1", name, stable);
    end
    n_vec++;
    if (bus4.sum !== es || bus4.cout !== ec || bus4.err !== ee) begin
      n_err++;
      $display("FAIL %s result: got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               name, bus4.sum, bus4.cout, bus4.err, es, ec, ee);
    end
    @(negedge clk);
    n_vec++;
    if (bus4.done !== 1'b0) begin
      n_err++; $display("FAIL %s done_pulse_width: got done=%b want 0", name, bus4.done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.a = '0; bus4.b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.cin = 1'b0; bus1.a = '0; bus1.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.err} !== 20'd0) begin
      n_err++;
      $display("FAIL reset4: got busy=%b done=%b sum=%h cout=%b err=%b want all 0",
               bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.err);
    end
    n_vec++;
    if ({bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.err} !== 8'd0) begin
      n_err++;
      $display("FAIL reset1: got busy=%b done=%b sum=%h cout=%b err=%b want all 0",
               bus1.busy, bus1.done, bus1.sum, bus1.cout, bus1.err);
    end
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h8766, 1'b0, 1'b0, "add_1234_8766");
    run_op(16'h0999, 16'h0001, 1'b0, 1'b0, "add_0999_0001");
    run_op(16'h9999, 16'h9999, 1'b0, 1'b1, "add_9999_9999_c");
    run_op(16'h5000, 16'h1234, 1'b1, 1'b0, "sub_5000_1234");
    run_op(16'h1234, 16'h5000, 1'b1, 1'b0, "sub_1234_5000");
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, "sub_0000_0000_b");
  endtask

  task automatic test_err();
    run_op(16'h12A4, 16'h0000, 1'b0, 1'b0, "err_a_nibble");
    run_op(16'h0001, 16'hF000, 1'b1, 1'b0, "err_b_nibble");
    run_op(16'h0042, 16'h0058, 1'b0, 1'b0, "err_cleared");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(1)), 1'($urandom_range(1)),
             "random");
    end
  endtask

  task automatic test_abort();
    run_op(16'h0005, 16'h0003, 1'b0, 1'b0, "pre_abort");
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.sub = 1'b0; bus4.cin = 1'b0;
    @(negedge clk);
    bus4.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.err} !== 20'd0) begin
      n_err++;
      $display("FAIL abort_reset: got busy=%b done=%b sum=%h cout=%b err=%b want all 0",
               bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.err);
    end
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (bus4.done || bus4.busy) seen++;
      end
      n_vec++;
      if (seen !== 0) begin
        n_err++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a2, b2, es;
    bit          s2, c2, ec, ee;
    int          cyc;
    a2 = rand_bcd(1'b0); b2 = rand_bcd(1'b0);
    s2 = 1'($urandom_range(1)); c2 = 1'($urandom_range(1));
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 16'h1234; bus4.b = 16'h8766; bus4.sub = 1'b0; bus4.cin = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus4.done && cyc < 20);
    n_vec++;
    if (!bus4.done || bus4.sum !== 16'h0000 || bus4.cout !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_first: got done=%b sum=%h cout=%b want done=1 sum=0000 cout=1",
               bus4.done, bus4.sum, bus4.cout);
    end
    bus4.a = a2; bus4.b = b2; bus4.sub = s2; bus4.cin = c2;
    @(negedge clk);
    bus4.start = 1'b0;
    n_vec++;
    if (bus4.busy !== 1'b1 || bus4.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", bus4.busy, bus4.done);
    end
    cyc = 1;
    while (!bus4.done && cyc < 20) begin @(negedge clk); cyc++; end
    n_vec++;
    if (cyc !== 5) begin
      n_err++; $display("FAIL b2b_spacing: got %0d want 5", cyc);
    end
    ref_model(a2, b2, s2, c2, 4, es, ec, ee);
    n_vec++;
    if (bus4.sum !== es || bus4.cout !== ec || bus4.err !== ee) begin
      n_err++;
      $display("FAIL b2b_second: got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
               bus4.sum, bus4.cout, bus4.err, es, ec, ee);
    end
    @(negedge clk);
  endtask

  task automatic test_digits1();
    logic [15:0] es;
    bit          ec, ee;
    logic [3:0]  a, b;
    bit          s, c;
    int          cyc, exp_lat;
    for (int i = 0; i < 21; i++) begin
      if (i == 0) begin
        a = 4'd9; b = 4'd9; s = 1'b0; c = 1'b1;
      end else begin
        a = 4'($urandom_range(9)); b = 4'($urandom_range(9));
        if ($urandom_range(7) == 0) a = 4'($urandom_range(15, 10));
        s = 1'($urandom_range(1)); c = 1'($urandom_range(1));
      end
      ref_model({12'd0, a}, {12'd0, b}, s, c, 1, es, ec, ee);
      exp_lat = ee ? 1 : 2;
      @(negedge clk);
      bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.sub = s; bus1.cin = c;
      cyc = 0;
      do begin
        @(negedge clk); cyc++; bus1.start = 1'b0;
      end while (!bus1.done && cyc < 10);
      n_vec++;
      if (cyc !== exp_lat) begin
        n_err++; $display("FAIL d1_latency: got %0d want %0d", cyc, exp_lat);
      end
      n_vec++;
      if (bus1.sum !== es[3:0] || bus1.cout !== ec || bus1.err !== ee) begin
        n_err++;
        $display("FAIL d1_result a=%h b=%h sub=%b cin=%b: got sum=%h cout=%b err=%b want sum=%h cout=%b err=%b",
                 a, b, s, c, bus1.sum, bus1.cout, bus1.err, es[3:0], ec, ee);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_err();
    test_random();
    test_abort();
    test_back_to_back();
    test_digits1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
